// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encodings, DR selector, opcodes and the TMS next-state function.
package jtag_pkg;

    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PS_DR  = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PS_IR  = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_t;

    typedef enum logic [2:0] {
        SEL_BYPASS,
        SEL_IDCODE,
        SEL_USERCODE,
        SEL_BSR,
        SEL_BIST
    } dr_sel_t;

    // Opcode values before zero-extension to the instruction register width
    localparam int OP_SAMPLE   = 1;
    localparam int OP_EXTEST   = 2;
    localparam int OP_INTEST   = 3;
    localparam int OP_RUNBIST  = 4;
    localparam int OP_CLAMP    = 5;
    localparam int OP_IDCODE   = 7;
    localparam int OP_USERCODE = 8;
    localparam int OP_HIGHZ    = 9;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = TLR;
        case (s)
            TLR:     n = tms ? TLR    : RTI;
            RTI:     n = tms ? SEL_DR : RTI;
            SEL_DR:  n = tms ? SEL_IR : CAP_DR;
            CAP_DR:  n = tms ? EX1_DR : SH_DR;
            SH_DR:   n = tms ? EX1_DR : SH_DR;
            EX1_DR:  n = tms ? UPD_DR : PS_DR;
            PS_DR:   n = tms ? EX2_DR : PS_DR;
            EX2_DR:  n = tms ? UPD_DR : SH_DR;
            UPD_DR:  n = tms ? SEL_DR : RTI;
            SEL_IR:  n = tms ? TLR    : CAP_IR;
            CAP_IR:  n = tms ? EX1_IR : SH_IR;
            SH_IR:   n = tms ? EX1_IR : SH_IR;
            EX1_IR:  n = tms ? UPD_IR : PS_IR;
            PS_IR:   n = tms ? EX2_IR : PS_IR;
            EX2_IR:  n = tms ? UPD_IR : SH_IR;
            UPD_IR:  n = tms ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_bscan_if.sv
// JTAG serial pins, boundary pad/core signals and BIST handshake of the TAP.
interface jtag_tap_bscan_if #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 8
);
    logic              TMS;
    logic              TDI;
    logic              TDO;
    logic              TDO_OE;
    logic [N_IN-1:0]   pin_in;
    logic [N_IN-1:0]   core_in;
    logic [N_OUT-1:0]  core_out;
    logic [N_OUT-1:0]  pin_out;
    logic              pin_oe;
    logic              bist_run;
    logic [1:0]        bist_stat;
    logic [3:0]        tap_state;

    modport master (
        output TMS, TDI, pin_in, core_out, bist_stat,
        input  TDO, TDO_OE, core_in, pin_out, pin_oe, bist_run, tap_state
    );

    modport slave (
        input  TMS, TDI, pin_in, core_out, bist_stat,
        output TDO, TDO_OE, core_in, pin_out, pin_oe, bist_run, tap_state
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller; TRST forces Test-Logic-Reset asynchronously.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_t state
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) state_q <= TLR;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        state_d = tap_next(state_q, TMS);
    end

    assign state = state_q;

endmodule

// File: rtl/jtag_tap_bscan.sv
// TAP with IR, BYPASS/IDCODE/USERCODE/BSR data registers and pad control.
// Optional RUNBIST status register is enabled by defining JTAG_RUNBIST_EN.
module jtag_tap_bscan
    import jtag_pkg::*;
#(
    parameter int          IR_W         = 4,
    parameter int          N_IN         = 8,
    parameter int          N_OUT        = 8,
    parameter logic [31:0] IDCODE_VAL   = 32'h1234_5A5B,
    parameter logic [31:0] USERCODE_VAL = 32'h0000_00C5
) (
    input  logic              TCK,
    input  logic              TRST,
    jtag_tap_bscan_if.slave   j
);

    localparam int BSR_W = N_IN + N_OUT;

    localparam logic [IR_W-1:0] IR_SAMPLE   = IR_W'(OP_SAMPLE);
    localparam logic [IR_W-1:0] IR_EXTEST   = IR_W'(OP_EXTEST);
    localparam logic [IR_W-1:0] IR_INTEST   = IR_W'(OP_INTEST);
    localparam logic [IR_W-1:0] IR_RUNBIST  = IR_W'(OP_RUNBIST);
    localparam logic [IR_W-1:0] IR_CLAMP    = IR_W'(OP_CLAMP);
    localparam logic [IR_W-1:0] IR_IDCODE   = IR_W'(OP_IDCODE);
    localparam logic [IR_W-1:0] IR_USERCODE = IR_W'(OP_USERCODE);
    localparam logic [IR_W-1:0] IR_HIGHZ    = IR_W'(OP_HIGHZ);

    tap_state_t          state;
    dr_sel_t             dr_sel;
    logic [IR_W-1:0]     ir_sr;
    logic [IR_W-1:0]     ir_act;
    logic                bypass_sr;
    logic [31:0]         id_sr;
    logic [BSR_W-1:0]    bsr_sr;
    logic [BSR_W-1:0]    bsr_upd;
    logic                bist_bit;
    logic                dr_bit;
    logic                tdo_q;

    // Anything not explicitly recognised falls back to the 1-bit bypass path
    function automatic dr_sel_t decode_dr(input logic [IR_W-1:0] ir);
        dr_sel_t sel;
        sel = SEL_BYPASS;
        if (ir == IR_IDCODE)                                        sel = SEL_IDCODE;
        else if (ir == IR_USERCODE)                                 sel = SEL_USERCODE;
        else if (ir == IR_SAMPLE || ir == IR_EXTEST || ir == IR_INTEST) sel = SEL_BSR;
`ifdef JTAG_RUNBIST_EN
        if (ir == IR_RUNBIST) sel = SEL_BIST;
`else
        if (ir == IR_RUNBIST) sel = SEL_BYPASS;
`endif
        return sel;
    endfunction

    jtag_tap_fsm u_fsm (
        .TCK   (TCK),
        .TRST  (TRST),
        .TMS   (j.TMS),
        .state (state)
    );

    assign dr_sel = decode_dr(ir_act);

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_sr <= '0;
        end else begin
            case (state)
                TLR:     ir_sr <= '0;
                CAP_IR:  ir_sr <= IR_W'(2'b01);
                SH_IR:   ir_sr <= {j.TDI, ir_sr[IR_W-1:1]};
                default: ir_sr <= ir_sr;
            endcase
        end
    end

    // Active instruction changes only on the falling edge so outputs never glitch mid-cycle
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST)                 ir_act <= IR_IDCODE;
        else if (state == TLR)    ir_act <= IR_IDCODE;
        else if (state == UPD_IR) ir_act <= ir_sr;
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            bypass_sr <= 1'b0;
            id_sr     <= '0;
            bsr_sr    <= '0;
        end else if (state == TLR) begin
            bypass_sr <= 1'b0;
            id_sr     <= '0;
            bsr_sr    <= '0;
        end else if (state == CAP_DR) begin
            case (dr_sel)
                SEL_IDCODE:   id_sr     <= IDCODE_VAL;
                SEL_USERCODE: id_sr     <= USERCODE_VAL;
                SEL_BSR:      bsr_sr    <= {j.core_out, j.pin_in};
                default:      bypass_sr <= 1'b0;
            endcase
        end else if (state == SH_DR) begin
            case (dr_sel)
                SEL_IDCODE, SEL_USERCODE: id_sr     <= {j.TDI, id_sr[31:1]};
                SEL_BSR:                  bsr_sr    <= {j.TDI, bsr_sr[BSR_W-1:1]};
                default:                  bypass_sr <= j.TDI;
            endcase
        end
    end

`ifdef JTAG_RUNBIST_EN
    logic [1:0] bist_sr;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST)                                        bist_sr <= '0;
        else if (state == TLR)                           bist_sr <= '0;
        else if (dr_sel == SEL_BIST && state == CAP_DR)  bist_sr <= j.bist_stat;
        else if (dr_sel == SEL_BIST && state == SH_DR)   bist_sr <= {j.TDI, bist_sr[1]};
    end

    assign bist_bit   = bist_sr[0];
    assign j.bist_run = (ir_act == IR_RUNBIST) && (state == RTI);
`else
    logic unused_bist;

    assign unused_bist = ^j.bist_stat;
    assign bist_bit    = 1'b0;
    assign j.bist_run  = 1'b0;
`endif

    // Held through Pause/Exit; only an Update-DR with the BSR selected commits shifted data
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST)                                       bsr_upd <= '0;
        else if (state == TLR)                          bsr_upd <= '0;
        else if (state == UPD_DR && dr_sel == SEL_BSR)  bsr_upd <= bsr_sr;
    end

    always_comb begin
        dr_bit = bypass_sr;
        case (dr_sel)
            SEL_IDCODE, SEL_USERCODE: dr_bit = id_sr[0];
            SEL_BSR:                  dr_bit = bsr_sr[0];
            SEL_BIST:                 dr_bit = bist_bit;
            default:                  dr_bit = bypass_sr;
        endcase
    end

    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST)                tdo_q <= 1'b0;
        else if (state == SH_IR) tdo_q <= ir_sr[0];
        else if (state == SH_DR) tdo_q <= dr_bit;
        else                     tdo_q <= 1'b0;
    end

    assign j.TDO       = tdo_q;
    assign j.TDO_OE    = (state == SH_IR) || (state == SH_DR);
    assign j.tap_state = state;

    assign j.pin_out = (ir_act == IR_EXTEST || ir_act == IR_CLAMP) ? bsr_upd[BSR_W-1:N_IN] : j.core_out;
    assign j.core_in = (ir_act == IR_INTEST) ? bsr_upd[N_IN-1:0] : j.pin_in;
    assign j.pin_oe  = (ir_act != IR_HIGHZ);

endmodule

// File: tb/tb_jtag_tap_bscan.sv
// Directed bench for jtag_tap_bscan: TDO bits are queued on stimulus and checked by a monitor.
// The RUNBIST section follows JTAG_RUNBIST_EN.
module tb_jtag_tap_bscan;

    localparam int IR_W  = 4;
    localparam int N_IN  = 8;
    localparam int N_OUT = 8;

    logic TCK;
    logic TRST;
    int   checks   = 0;
    int   failures = 0;
    logic exp_q[$];

    jtag_tap_bscan_if #(.N_IN(N_IN), .N_OUT(N_OUT)) j();

    jtag_tap_bscan #(
        .IR_W         (IR_W),
        .N_IN         (N_IN),
        .N_OUT        (N_OUT),
        .IDCODE_VAL   (32'h1234_5A5B),
        .USERCODE_VAL (32'h0000_00C5)
    ) dut (
        .TCK  (TCK),
        .TRST (TRST),
        .j    (j)
    );

    initial begin
        TCK = 1'b0;
        forever #10 TCK = ~TCK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // One TCK cycle: drive TMS/TDI after the falling edge, return just after the rising edge
    task automatic applyStimulus(input logic tms, input logic tdi);
        @(negedge TCK);
        #1;
        j.TMS = tms;
        j.TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    task automatic toRti();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic loadIr(input logic [IR_W-1:0] op);
        for (int i = 0; i < IR_W; i++) exp_q.push_back(i == 0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < IR_W; i++) applyStimulus(i == IR_W - 1, op[i]);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    // From RTI: capture, shift n bits and stop in Exit1-DR
    task automatic shiftDr(input int n, input logic [63:0] din, input logic [63:0] dout);
        for (int i = 0; i < n; i++) exp_q.push_back(dout[i]);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("shdr_state", 32'(j.tap_state), 32'h2);
        checkOutput("shdr_oe", 32'(j.TDO_OE), 32'h1);
        for (int i = 0; i < n; i++) applyStimulus(i == n - 1, din[i]);
    endtask

    initial begin
        logic e;
        forever begin
            @(negedge TCK);
            #2;
            if (j.TDO_OE === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL tdo_unexpected actual=%0b expected=none", j.TDO);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("tdo", 32'(j.TDO), 32'(e));
                end
            end
        end
    end

    initial begin
        TRST        = 1'b1;
        j.TMS       = 1'b1;
        j.TDI       = 1'b0;
        j.pin_in    = 8'hA5;
        j.core_out  = 8'h3C;
        j.bist_stat = 2'b11;
        repeat (2) @(negedge TCK);
        #1;
        TRST = 1'b0;
        #1;
        checkOutput("rst_state", 32'(j.tap_state), 32'hF);
        checkOutput("rst_tdo", 32'(j.TDO), 32'h0);
        checkOutput("rst_tdo_oe", 32'(j.TDO_OE), 32'h0);
        checkOutput("rst_pin_oe", 32'(j.pin_oe), 32'h1);
        checkOutput("rst_bist_run", 32'(j.bist_run), 32'h0);
        checkOutput("rst_pin_out", 32'(j.pin_out), 32'h3C);
        checkOutput("rst_core_in", 32'(j.core_in), 32'hA5);

        applyStimulus(1'b0, 1'b0);
        checkOutput("rti_state", 32'(j.tap_state), 32'hC);
        checkOutput("rti_tdo_oe", 32'(j.TDO_OE), 32'h0);

        shiftDr(32, 64'h0, 64'h1234_5A5B);
        toRti();
        checkOutput("idcode_done_oe", 32'(j.TDO_OE), 32'h0);

        loadIr(4'hF);
        shiftDr(10, 64'h204, 64'h008);
        toRti();

        loadIr(4'h1);
        shiftDr(16, 64'h0, 64'h3CA5);
        toRti();
        checkOutput("sample_pin_out", 32'(j.pin_out), 32'h3C);
        checkOutput("sample_core_in", 32'(j.core_in), 32'hA5);
        checkOutput("sample_pin_oe", 32'(j.pin_oe), 32'h1);

        loadIr(4'h2);
        checkOutput("extest_pin_out0", 32'(j.pin_out), 32'h00);
        shiftDr(16, 64'h6F00, 64'h3CA5);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("pause_state", 32'(j.tap_state), 32'h3);
            checkOutput("pause_pin_out", 32'(j.pin_out), 32'h00);
        end
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("upd_state", 32'(j.tap_state), 32'h5);
        checkOutput("upd_pin_out_pre", 32'(j.pin_out), 32'h00);
        applyStimulus(1'b0, 1'b0);
        checkOutput("extest_pin_out", 32'(j.pin_out), 32'h6F);
        checkOutput("extest_core_in", 32'(j.core_in), 32'hA5);

        loadIr(4'h8);
        shiftDr(32, 64'h0, 64'h0000_00C5);
        toRti();

        loadIr(4'h9);
        checkOutput("highz_pin_oe", 32'(j.pin_oe), 32'h0);
        checkOutput("highz_pin_out", 32'(j.pin_out), 32'h3C);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("tlr_state", 32'(j.tap_state), 32'hF);
        checkOutput("tlr_pin_oe", 32'(j.pin_oe), 32'h1);
        applyStimulus(1'b0, 1'b0);
        shiftDr(32, 64'h0, 64'h1234_5A5B);
        toRti();

        loadIr(4'h2);
        checkOutput("extest2_pin_out", 32'(j.pin_out), 32'h00);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
        TRST = 1'b1;
        #1;
        checkOutput("trst_state", 32'(j.tap_state), 32'hF);
        checkOutput("trst_pin_out", 32'(j.pin_out), 32'h3C);
        checkOutput("trst_tdo", 32'(j.TDO), 32'h0);
        checkOutput("trst_tdo_oe", 32'(j.TDO_OE), 32'h0);
        @(negedge TCK);
        #1;
        TRST = 1'b0;

        applyStimulus(1'b0, 1'b0);
        loadIr(4'h4);
`ifdef JTAG_RUNBIST_EN
        checkOutput("bist_run_rti", 32'(j.bist_run), 32'h1);
        shiftDr(2, 64'h0, 64'h3);
        toRti();
        checkOutput("bist_run_again", 32'(j.bist_run), 32'h1);
`else
        checkOutput("bist_run_off", 32'(j.bist_run), 32'h0);
        shiftDr(2, 64'h1, 64'h2);
        toRti();
        checkOutput("bist_run_off2", 32'(j.bist_run), 32'h0);
`endif

        repeat (3) @(negedge TCK);
        #5;
        checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
